// File: rtl/pad_cfg_loader.sv
// pad_cfg_loader: boot-time sequencer that walks a pad-register table and issues each
// entry as a config write. Optional read-back check: PAD_CFG_LOADER_VERIFY_EN.
module pad_cfg_loader #(
  parameter int NUM_ENTRIES    = 16,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDX_W         = $clog2(NUM_ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [IDX_W:0]   num_entries_i,
  output logic [IDX_W-1:0] tbl_idx_o,
  input  logic [31:0]      tbl_addr_i,
  input  logic [31:0]      tbl_wdata_i,
  input  logic [3:0]       tbl_wstrb_i,
  output logic [31:0]      cfg_addr_o,
  output logic             cfg_write_o,
  output logic [31:0]      cfg_wdata_o,
  output logic [3:0]       cfg_wstrb_o,
  output logic             cfg_valid_o,
  input  logic [31:0]      cfg_rdata_i,
  input  logic             cfg_error_i,
  input  logic             cfg_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [IDX_W-1:0] err_idx_o,
  output logic [1:0]       err_code_o
);

  localparam int CNT_W = IDX_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_NEXT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
`ifdef PAD_CFG_LOADER_VERIFY_EN
    , ST_VERIFY = 3'd5
`endif
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_in_s;
  logic [TO_W-1:0]  wait_r;
  logic             valid_r;
  logic             write_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic [IDX_W-1:0] err_idx_r;
  logic [1:0]       err_code_r;
  logic             start_acc_s;
  logic             idx_inc_s;
  logic             fail_s;
  logic [1:0]       fail_code_s;
  logic             last_s;
  logic             timeout_s;

`ifdef PAD_CFG_LOADER_VERIFY_EN
  function automatic logic readback_mismatch(input logic [31:0] wdata,
                                             input logic [31:0] rdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{wstrb[b]}};
    end
    return ((wdata ^ rdata) & mask) != 32'd0;
  endfunction
`else
  logic rdata_unused_s;
  assign rdata_unused_s = ^cfg_rdata_i;
`endif

  // Out-of-range counts are clamped so the index can never run past the table.
  assign count_in_s = (num_entries_i > CNT_W'(NUM_ENTRIES)) ? CNT_W'(NUM_ENTRIES) : num_entries_i;
  assign last_s     = (({1'b0, idx_r} + CNT_W'(1)) == count_r);
  assign timeout_s  = (wait_r == TO_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and transition control.
  always_comb begin
    state_s     = state_r;
    start_acc_s = 1'b0;
    idx_inc_s   = 1'b0;
    fail_s      = 1'b0;
    fail_code_s = 2'd0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          start_acc_s = 1'b1;
          if (count_in_s == {CNT_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (cfg_ready_i) begin
          if (cfg_error_i) begin
            state_s     = ST_FAIL;
            fail_s      = 1'b1;
            fail_code_s = 2'd1;
          end else begin
`ifdef PAD_CFG_LOADER_VERIFY_EN
            state_s = ST_VERIFY;
`else
            state_s = ST_NEXT;
`endif
          end
        end else if (timeout_s) begin
          state_s     = ST_FAIL;
          fail_s      = 1'b1;
          fail_code_s = 2'd2;
        end else begin
          state_s = ST_REQ;
        end
      end
`ifdef PAD_CFG_LOADER_VERIFY_EN
      ST_VERIFY: begin
        if (cfg_ready_i) begin
          if (cfg_error_i) begin
            state_s     = ST_FAIL;
            fail_s      = 1'b1;
            fail_code_s = 2'd1;
          end else if (readback_mismatch(tbl_wdata_i, cfg_rdata_i, tbl_wstrb_i)) begin
            state_s     = ST_FAIL;
            fail_s      = 1'b1;
            fail_code_s = 2'd3;
          end else begin
            state_s = ST_NEXT;
          end
        end else if (timeout_s) begin
          state_s     = ST_FAIL;
          fail_s      = 1'b1;
          fail_code_s = 2'd2;
        end else begin
          state_s = ST_VERIFY;
        end
      end
`endif
      ST_NEXT: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          idx_inc_s = 1'b1;
          state_s   = ST_REQ;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_FAIL: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath and registered status; flags are decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_r      <= {IDX_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      wait_r     <= {TO_W{1'b0}};
      valid_r    <= 1'b0;
      write_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_idx_r  <= {IDX_W{1'b0}};
      err_code_r <= 2'd0;
    end else begin
`ifdef PAD_CFG_LOADER_VERIFY_EN
      valid_r <= (state_s == ST_REQ) || (state_s == ST_VERIFY);
`else
      valid_r <= (state_s == ST_REQ);
`endif
      write_r <= (state_s == ST_REQ);
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      // The wait counter restarts whenever a request is newly issued.
      if (valid_r && (state_s == state_r)) begin
        wait_r <= wait_r + TO_W'(1);
      end else begin
        wait_r <= {TO_W{1'b0}};
      end
      if (start_acc_s) begin
        idx_r   <= {IDX_W{1'b0}};
        count_r <= count_in_s;
      end else if (idx_inc_s) begin
        idx_r   <= idx_r + IDX_W'(1);
        count_r <= count_r;
      end else begin
        idx_r   <= idx_r;
        count_r <= count_r;
      end
      if (start_acc_s) begin
        error_r    <= 1'b0;
        err_idx_r  <= {IDX_W{1'b0}};
        err_code_r <= 2'd0;
      end else if (fail_s) begin
        error_r    <= 1'b1;
        err_idx_r  <= idx_r;
        err_code_r <= fail_code_s;
      end else begin
        error_r    <= error_r;
        err_idx_r  <= err_idx_r;
        err_code_r <= err_code_r;
      end
    end
  end

  assign tbl_idx_o   = idx_r;
  assign cfg_valid_o = valid_r;
  assign cfg_write_o = write_r;
  assign cfg_addr_o  = valid_r ? tbl_addr_i  : 32'd0;
  assign cfg_wdata_o = write_r ? tbl_wdata_i : 32'd0;
  assign cfg_wstrb_o = write_r ? tbl_wstrb_i : 4'd0;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign error_o     = error_r;
  assign err_idx_o   = err_idx_r;
  assign err_code_o  = err_code_r;

endmodule

// File: doc/pad_cfg_loader.md
Name: pad_cfg_loader

Overview:
Initiator for the padframe configuration request/response port: walks a table of pad-register writes after reset and issues them over the valid/ready config interface. Sits between the SoC boot control and the padframe's config port. It replaces host- or testbench-driven pad programming with a deterministic hardware sequencer that has per-transfer timeout and error capture.

Parameters:
NUM_ENTRIES, 16, maximum table depth; index width IDX_W = $clog2(NUM_ENTRIES).
TIMEOUT_CYCLES, 255, maximum cycles valid may wait for ready per transfer; must be >= 1.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  pulse; starts a load sequence when idle
num_entries_i  in  IDX_W+1  entries to process (0..NUM_ENTRIES), sampled on accepted start
tbl_idx_o  out  IDX_W  current table index (combinational lookup by parent)
tbl_addr_i  in  32  register address for tbl_idx_o
tbl_wdata_i  in  32  write data for tbl_idx_o
tbl_wstrb_i  in  4  byte strobes for tbl_idx_o
cfg_addr_o  out  32  request address
cfg_write_o  out  1  request is write
cfg_wdata_o  out  32  request write data
cfg_wstrb_o  out  4  request byte strobes
cfg_valid_o  out  1  request valid
cfg_rdata_i  in  32  response read data
cfg_error_i  in  1  response error, valid when valid&&ready
cfg_ready_i  in  1  transfer accepted/completed this cycle
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse on successful completion
error_o  out  1  sticky; set on failure, cleared by next accepted start
err_idx_o  out  IDX_W  index of failing entry
err_code_o  out  2  0 none, 1 slave error, 2 timeout, 3 verify mismatch

Behaviour:
- Reset (rst_i high at clock edge): state IDLE; all outputs 0; counters 0. Reset mid-transfer drops cfg_valid_o on the next cycle, with no completion.
- States: IDLE, REQ, NEXT, DONE, FAIL (plus VERIFY with the optional feature).
- IDLE: start_i=1 -> clear error_o/err_code_o/err_idx_o, latch count, idx=0; count=0 -> DONE, else -> REQ. start_i is ignored in any other state.
- REQ: cfg_valid_o=1, cfg_write_o=1, fields driven from the table at idx, held stable while valid && !ready. Transfer completes in the cycle valid && ready; rdata/error are sampled that cycle.
  - error=1 -> FAIL, code 1.
  - otherwise -> NEXT (or VERIFY).
  - No ready after TIMEOUT_CYCLES cycles of valid -> drop valid, FAIL, code 2.
- Timeout counter resets on every new request. valid deasserts the cycle after the completing handshake, so back-to-back requests have one idle cycle.
- NEXT: idx+1; idx == count-1 -> DONE, else -> REQ. One cycle.
- DONE: done_o=1 for exactly one cycle -> IDLE.
- FAIL: error_o=1, err_idx_o=idx, one cycle -> IDLE. error_o stays sticky.
- busy_o=1 in every state except IDLE.
- Minimum latency for N entries with immediate ready: start -> done_o = 2N+1 cycles (N REQ + N NEXT + 1 DONE; count=0 gives 1).
- tbl_idx_o is registered and changes only in NEXT.

Optional Feature:
PAD_CFG_LOADER_VERIFY_EN:
- Defined: after each successful write, enter VERIFY and issue a read (cfg_write_o=0, wstrb=0) to the same address, with the same handshake and timeout rules.
- Compare (rdata ^ wdata) masked per byte by the original wstrb.
  - mismatch -> FAIL, code 3.
  - slave error on the read -> code 1; timeout -> code 2.
  - match -> NEXT.
- Latency becomes 3N+1.
- Undefined: VERIFY state absent; code 3 is never produced.

Test Plan:
- Reset then num_entries=3, ready tied 1 -> three writes with table addr/data in order, each valid for 1 cycle; done_o at cycle 7 after start; error_o=0.
- num_entries=0, start pulse -> no cfg_valid_o; done_o exactly 1 cycle after start.
- Ready withheld 5 cycles on entry 1 -> addr/wdata/wstrb stable across all 5 wait cycles; sequence completes normally.
- Ready never asserted on entry 2, TIMEOUT_CYCLES=255 -> valid drops after 255 cycles; error_o=1, err_idx_o=2, err_code_o=2, no done_o.
- cfg_error_i=1 on entry 0 handshake -> err_code_o=1, err_idx_o=0; next start clears error_o and reruns.
- VERIFY_EN, wstrb=4'b0011, wdata=0x1234_5678, rdata=0xFFFF_5678 -> pass; rdata=0x0000_5679 -> err_code_o=3.
